// File: rtl/surf_wb_intercon_if.sv
// WISHBONE classic bus bundle shared by the commanding masters and the register slaves.
// The master modport is the bus initiator's view; the slave modport is the target's view.
interface surf_wb_intercon_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [21:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;

    modport master (
        output cyc, stb, we, adr, sel, wdat,
        input  rdat, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, wdat,
        output rdat, ack
    );
endinterface

// File: rtl/surf_wb_intercon.sv
// Two-master (bm serial, tc TURF) to two-slave WISHBONE classic interconnect, split on adr[21].
// Optional stalled-slave timeout is compiled in with the WB_TIMEOUT_EN macro.
module surf_wb_intercon #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADDEAD
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    surf_wb_intercon_if.slave  bm,
    surf_wb_intercon_if.slave  tc,
    surf_wb_intercon_if.master s0,
    surf_wb_intercon_if.master s1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_BM = 2'd1,
        GNT_TC = 2'd2
    } arb_state_t;

    arb_state_t  state_r;
    logic        last_tc_r;

    logic        gnt_bm_s;
    logic        gnt_tc_s;
    logic        path_s;
    logic        m_cyc_s;
    logic        m_stb_s;
    logic        m_we_s;
    logic [21:0] m_adr_s;
    logic [3:0]  m_sel_s;
    logic [31:0] m_wdat_s;
    logic        to_s1_s;
    logic        stb_mask_s;
    logic        to_hit_s;
    logic        slv_ack_s;
    logic        m_ack_s;
    logic [31:0] rd_dat_s;

    // Round-robin arbiter: last_tc_r remembers who held the previous grant (tc after reset so bm wins the first tie).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r   <= IDLE;
            last_tc_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bm.cyc && tc.cyc) begin
                        if (last_tc_r) begin
                            state_r   <= GNT_BM;
                            last_tc_r <= 1'b0;
                        end else begin
                            state_r   <= GNT_TC;
                            last_tc_r <= 1'b1;
                        end
                    end else if (bm.cyc) begin
                        state_r   <= GNT_BM;
                        last_tc_r <= 1'b0;
                    end else if (tc.cyc) begin
                        state_r   <= GNT_TC;
                        last_tc_r <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                GNT_BM: begin
                    if (!bm.cyc) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= GNT_BM;
                    end
                end
                GNT_TC: begin
                    if (!tc.cyc) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= GNT_TC;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign gnt_bm_s = (state_r == GNT_BM);
    assign gnt_tc_s = (state_r == GNT_TC);

    // Granted-master mux; while idle the shared slave bus simply follows bm.
    always_comb begin
        m_cyc_s  = bm.cyc;
        m_stb_s  = bm.stb;
        m_we_s   = bm.we;
        m_adr_s  = bm.adr;
        m_sel_s  = bm.sel;
        m_wdat_s = bm.wdat;
        if (gnt_tc_s) begin
            m_cyc_s  = tc.cyc;
            m_stb_s  = tc.stb;
            m_we_s   = tc.we;
            m_adr_s  = tc.adr;
            m_sel_s  = tc.sel;
            m_wdat_s = tc.wdat;
        end else begin
            m_cyc_s  = bm.cyc;
            m_stb_s  = bm.stb;
            m_we_s   = bm.we;
            m_adr_s  = bm.adr;
            m_sel_s  = bm.sel;
            m_wdat_s = bm.wdat;
        end
    end

    assign path_s  = (gnt_bm_s || gnt_tc_s) && m_cyc_s;
    assign to_s1_s = m_adr_s[21];

`ifdef WB_TIMEOUT_EN
    logic [15:0] to_cnt_r;
    logic        to_mask_r;

    assign to_hit_s   = path_s && m_stb_s && !to_mask_r && (to_cnt_r == TIMEOUT_CYCLES[15:0]);
    // The slave is kept off the bus from the forced completion until the master releases stb.
    assign stb_mask_s = to_mask_r || to_hit_s;

    // Wait counter for the live strobe; frozen at zero while the masked strobe is still held.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt_r  <= 16'd0;
            to_mask_r <= 1'b0;
        end else if (path_s && m_stb_s && !to_mask_r) begin
            if (m_ack_s) begin
                to_cnt_r  <= 16'd0;
                to_mask_r <= to_hit_s;
            end else begin
                to_cnt_r  <= to_cnt_r + 16'd1;
                to_mask_r <= 1'b0;
            end
        end else begin
            to_cnt_r  <= 16'd0;
            to_mask_r <= to_mask_r && path_s && m_stb_s;
        end
    end
`else
    logic unused_cfg_s;

    assign to_hit_s     = 1'b0;
    assign stb_mask_s   = 1'b0;
    assign unused_cfg_s = ^TIMEOUT_CYCLES;
`endif

    // Shared address/data fan-out; only the addressed slave sees cyc/stb.
    always_comb begin
        s0.we   = m_we_s;
        s0.adr  = m_adr_s;
        s0.sel  = m_sel_s;
        s0.wdat = m_wdat_s;
        s0.cyc  = path_s && !to_s1_s;
        s0.stb  = path_s && !to_s1_s && m_stb_s && !stb_mask_s;
        s1.we   = m_we_s;
        s1.adr  = m_adr_s;
        s1.sel  = m_sel_s;
        s1.wdat = m_wdat_s;
        s1.cyc  = path_s && to_s1_s;
        s1.stb  = path_s && to_s1_s && m_stb_s && !stb_mask_s;
    end

    assign slv_ack_s = to_s1_s ? s1.ack : s0.ack;
    assign m_ack_s   = (path_s && m_stb_s && !stb_mask_s && slv_ack_s) || to_hit_s;
    assign rd_dat_s  = to_hit_s ? TIMEOUT_DATA : (to_s1_s ? s1.rdat : s0.rdat);

    // Zero-latency return path to the granted master only.
    always_comb begin
        bm.ack  = gnt_bm_s && m_ack_s;
        tc.ack  = gnt_tc_s && m_ack_s;
        bm.rdat = gnt_bm_s ? rd_dat_s : 32'd0;
        tc.rdat = gnt_tc_s ? rd_dat_s : 32'd0;
    end

endmodule

// File: tb/tb_surf_wb_intercon.sv
// Self-checking bench for surf_wb_intercon: a cycle-level ownership model checked every cycle,
// plus directed scenarios with hand-computed expectations. Honours WB_TIMEOUT_EN like the design.
module tb_surf_wb_intercon;
    localparam int unsigned TO = 8;
    localparam logic [31:0] TD = 32'hDEADDEAD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        bm_cyc, bm_stb, bm_we, tc_cyc, tc_stb, tc_we;
    logic [21:0] bm_adr, tc_adr;
    logic [3:0]  bm_sel, tc_sel;
    logic [31:0] bm_wdat, tc_wdat;

    surf_wb_intercon_if bm_if ();
    surf_wb_intercon_if tc_if ();
    surf_wb_intercon_if s0_if ();
    surf_wb_intercon_if s1_if ();

    assign bm_if.cyc = bm_cyc;  assign bm_if.stb = bm_stb;  assign bm_if.we = bm_we;
    assign bm_if.adr = bm_adr;  assign bm_if.sel = bm_sel;  assign bm_if.wdat = bm_wdat;
    assign tc_if.cyc = tc_cyc;  assign tc_if.stb = tc_stb;  assign tc_if.we = tc_we;
    assign tc_if.adr = tc_adr;  assign tc_if.sel = tc_sel;  assign tc_if.wdat = tc_wdat;

    surf_wb_intercon #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(TD)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bm       (bm_if),
        .tc       (tc_if),
        .s0       (s0_if),
        .s1       (s1_if)
    );

    // Slave responders: ack on the lat-th strobe cycle after the strobe appears (lat < 0 never acks).
    int lat0 = -1, lat1 = -1, w0 = 0, w1 = 0;
    logic [31:0] rd0 = 32'd0, rd1 = 32'd0;
    assign s0_if.ack  = s0_if.stb && (lat0 >= 0) && (w0 == lat0);
    assign s1_if.ack  = s1_if.stb && (lat1 >= 0) && (w1 == lat1);
    assign s0_if.rdat = rd0;
    assign s1_if.rdat = rd1;
    always @(posedge clk) w0 <= (s0_if.stb && !s0_if.ack) ? w0 + 1 : 0;
    always @(posedge clk) w1 <= (s1_if.stb && !s1_if.ack) ? w1 + 1 : 0;

    // Model: owner 0 = nobody, 1 = bm, 2 = tc; last = previous owner.
    int owner = 0, last = 2, tcnt = 0;
    bit tmask = 1'b0;
    int total = 0, bad = 0;

    logic        sn_bm_ack, sn_tc_ack, sn_s0_cyc, sn_s0_stb, sn_s1_cyc, sn_s1_stb, sn_s1_we;
    logic [31:0] sn_bm_dat, sn_tc_dat, sn_s1_wdat;
    logic [21:0] sn_s1_adr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic cc, cs, cw, g, s1sel, hit, meff, e0c, e0s, e1c, e1s, sack, mack;
        logic [21:0] ca;
        logic [3:0]  csel;
        logic [31:0] cd, rdat;
        int n_owner, n_last, n_cnt;
        bit n_mask;
        @(negedge clk);
        if (owner == 2) begin
            cc = tc_cyc; cs = tc_stb; cw = tc_we; ca = tc_adr; csel = tc_sel; cd = tc_wdat;
        end else begin
            cc = bm_cyc; cs = bm_stb; cw = bm_we; ca = bm_adr; csel = bm_sel; cd = bm_wdat;
        end
        g     = (owner != 0) && cc;
        s1sel = ca[21];
`ifdef WB_TIMEOUT_EN
        hit = g && cs && !tmask && (tcnt == int'(TO));
`else
        hit = 1'b0;
`endif
        meff = tmask || hit;
        e0c  = g && !s1sel;
        e1c  = g && s1sel;
        e0s  = e0c && cs && !meff;
        e1s  = e1c && cs && !meff;
        sack = s1sel ? (e1s && lat1 >= 0 && w1 == lat1) : (e0s && lat0 >= 0 && w0 == lat0);
        mack = sack || hit;
        rdat = hit ? TD : (s1sel ? rd1 : rd0);
        chk("s0_cyc", 32'(s0_if.cyc), 32'(e0c));
        chk("s0_stb", 32'(s0_if.stb), 32'(e0s));
        chk("s1_cyc", 32'(s1_if.cyc), 32'(e1c));
        chk("s1_stb", 32'(s1_if.stb), 32'(e1s));
        chk("bm_ack", 32'(bm_if.ack), 32'(owner == 1 && mack));
        chk("tc_ack", 32'(tc_if.ack), 32'(owner == 2 && mack));
        chk("bm_dat", bm_if.rdat, (owner == 1) ? rdat : 32'd0);
        chk("tc_dat", tc_if.rdat, (owner == 2) ? rdat : 32'd0);
        if (owner != 0) begin
            chk("s0_adr", 32'(s0_if.adr), 32'(ca));
            chk("s1_adr", 32'(s1_if.adr), 32'(ca));
            chk("s0_we",  32'(s0_if.we),  32'(cw));
            chk("s1_we",  32'(s1_if.we),  32'(cw));
            chk("s0_sel", 32'(s0_if.sel), 32'(csel));
            chk("s1_sel", 32'(s1_if.sel), 32'(csel));
            chk("s0_wdat", s0_if.wdat, cd);
            chk("s1_wdat", s1_if.wdat, cd);
        end
        sn_bm_ack = bm_if.ack;  sn_tc_ack = tc_if.ack;  sn_bm_dat = bm_if.rdat;  sn_tc_dat = tc_if.rdat;
        sn_s0_cyc = s0_if.cyc;  sn_s0_stb = s0_if.stb;  sn_s1_cyc = s1_if.cyc;  sn_s1_stb = s1_if.stb;
        sn_s1_we  = s1_if.we;   sn_s1_adr = s1_if.adr;  sn_s1_wdat = s1_if.wdat;

        n_owner = owner; n_last = last; n_cnt = tcnt; n_mask = tmask;
        if (rst) begin
            n_owner = 0; n_last = 2; n_cnt = 0; n_mask = 1'b0;
        end else begin
            if (g && cs && !tmask) begin
                if (mack) begin
                    n_cnt = 0; n_mask = hit;
                end else begin
                    n_cnt = tcnt + 1;
                end
            end else begin
                n_cnt = 0; n_mask = tmask && g && cs;
            end
            if (owner == 0) begin
                if (bm_cyc && tc_cyc) n_owner = (last == 1) ? 2 : 1;
                else if (bm_cyc)      n_owner = 1;
                else if (tc_cyc)      n_owner = 2;
                if (n_owner != 0) n_last = n_owner;
            end else if (!cc) begin
                n_owner = 0;
            end
        end
        @(posedge clk);
        owner = n_owner; last = n_last; tcnt = n_cnt; tmask = n_mask;
        #1;
    endtask

    int ack_at, first_stb, n_ack, n_tc_ack;
    bit s1_seen, tc_acked;
    logic [31:0] got_dat;

    initial begin
        rst = 1'b1;
        bm_cyc = 1'b0; bm_stb = 1'b0; bm_we = 1'b0; bm_adr = 22'd0; bm_sel = 4'd0; bm_wdat = 32'd0;
        tc_cyc = 1'b0; tc_stb = 1'b0; tc_we = 1'b0; tc_adr = 22'd0; tc_sel = 4'd0; tc_wdat = 32'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_bm_ack", 32'(sn_bm_ack), 32'd0);
        chk("rst_tc_ack", 32'(sn_tc_ack), 32'd0);
        chk("rst_s0_cyc", 32'(sn_s0_cyc), 32'd0);
        chk("rst_s1_stb", 32'(sn_s1_stb), 32'd0);

        // bm read from s0, slave answers two cycles after it sees stb
        lat0 = 2; rd0 = 32'h12345678;
        bm_cyc = 1'b1; bm_stb = 1'b1; bm_we = 1'b0; bm_adr = 22'h000004; bm_sel = 4'hF;
        tick();
        chk("rd_stb_n", 32'(sn_s0_stb), 32'd0);
        ack_at = -1; first_stb = -1; s1_seen = 1'b0; tc_acked = 1'b0; got_dat = 32'd0;
        for (int i = 1; i <= 10 && ack_at < 0; i++) begin
            tick();
            if (sn_s0_stb && first_stb < 0) first_stb = i;
            if (sn_s1_cyc || sn_s1_stb) s1_seen = 1'b1;
            if (sn_tc_ack) tc_acked = 1'b1;
            if (sn_bm_ack) begin ack_at = i; got_dat = sn_bm_dat; end
        end
        bm_cyc = 1'b0; bm_stb = 1'b0;
        chk("rd_stb_rise", 32'(first_stb), 32'd1);
        chk("rd_ack_cycle", 32'(ack_at), 32'd3);
        chk("rd_data", got_dat, 32'h12345678);
        chk("rd_tc_ack", 32'(tc_acked), 32'd0);
        chk("rd_s1_idle", 32'(s1_seen), 32'd0);
        tick(); tick();

        // tc write into s1
        lat1 = 1;
        tc_cyc = 1'b1; tc_stb = 1'b1; tc_we = 1'b1; tc_adr = 22'h200010; tc_sel = 4'hF; tc_wdat = 32'hA5A5A5A5;
        tick(); tick();
        chk("wr_s1_cyc", 32'(sn_s1_cyc), 32'd1);
        chk("wr_s1_stb", 32'(sn_s1_stb), 32'd1);
        chk("wr_s1_we", 32'(sn_s1_we), 32'd1);
        chk("wr_s1_dat", sn_s1_wdat, 32'hA5A5A5A5);
        chk("wr_s1_adr", 32'(sn_s1_adr), 32'h00200010);
        chk("wr_s0_stb", 32'(sn_s0_stb), 32'd0);
        tick();
        chk("wr_tc_ack", 32'(sn_tc_ack), 32'd1);
        chk("wr_bm_ack", 32'(sn_bm_ack), 32'd0);
        tc_cyc = 1'b0; tc_stb = 1'b0; tc_we = 1'b0;
        tick(); tick();

        // ties after a fresh reset: bm first, then round-robin
        rst = 1'b1; tick(); rst = 1'b0;
        lat0 = 0; rd0 = 32'h0BADF00D;
        bm_adr = 22'h000008; tc_adr = 22'h00000C; tc_we = 1'b0;
        bm_cyc = 1'b1; bm_stb = 1'b1; tc_cyc = 1'b1; tc_stb = 1'b1;
        tick(); tick();
        chk("tie1_bm_ack", 32'(sn_bm_ack), 32'd1);
        chk("tie1_tc_ack", 32'(sn_tc_ack), 32'd0);
        tick();
        bm_cyc = 1'b0; bm_stb = 1'b0;
        tick(); chk("tie1_wait_a", 32'(sn_tc_ack), 32'd0);
        tick(); chk("tie1_wait_b", 32'(sn_tc_ack), 32'd0);
        tick(); chk("tie1_tc_ack", 32'(sn_tc_ack), 32'd1);
        tc_cyc = 1'b0; tc_stb = 1'b0;
        tick(); tick();
        bm_cyc = 1'b1; bm_stb = 1'b1;
        tick(); tick();
        chk("solo_bm_ack", 32'(sn_bm_ack), 32'd1);
        bm_cyc = 1'b0; bm_stb = 1'b0;
        tick(); tick();
        bm_cyc = 1'b1; bm_stb = 1'b1; tc_cyc = 1'b1; tc_stb = 1'b1;
        tick(); tick();
        chk("tie2_tc_ack", 32'(sn_tc_ack), 32'd1);
        chk("tie2_bm_ack", 32'(sn_bm_ack), 32'd0);
        chk("tie2_tc_dat", sn_tc_dat, 32'h0BADF00D);
        // tc releases in the same cycle bm is still waiting; then a drop/raise handover back to tc
        tc_cyc = 1'b0; tc_stb = 1'b0;
        tick(); tick(); tick();
        chk("tie2_bm_late", 32'(sn_bm_ack), 32'd1);
        bm_cyc = 1'b0; bm_stb = 1'b0; tc_cyc = 1'b1; tc_stb = 1'b1;
        tick(); chk("hand_a", 32'(sn_tc_ack), 32'd0);
        tick(); chk("hand_b", 32'(sn_tc_ack), 32'd0);
        tick(); chk("hand_tc_ack", 32'(sn_tc_ack), 32'd1);
        tc_cyc = 1'b0; tc_stb = 1'b0;
        tick(); tick();

        // bm holds cyc through three back-to-back strobes while tc waits
        lat0 = 1; bm_adr = 22'h000020;
        bm_cyc = 1'b1; bm_stb = 1'b1;
        tick();
        tc_cyc = 1'b1; tc_stb = 1'b1;
        n_ack = 0; n_tc_ack = 0;
        for (int i = 0; i < 12 && n_ack < 3; i++) begin
            tick();
            if (sn_bm_ack) n_ack++;
            if (sn_tc_ack) n_tc_ack++;
        end
        chk("burst_acks", 32'(n_ack), 32'd3);
        chk("burst_tc_held", 32'(n_tc_ack), 32'd0);
        lat0 = 0; bm_cyc = 1'b0; bm_stb = 1'b0;
        tick(); tick(); tick();
        chk("burst_tc_after", 32'(sn_tc_ack), 32'd1);
        tc_cyc = 1'b0; tc_stb = 1'b0;
        tick(); tick();

        // s1 never answers
        lat1 = -1; rd1 = 32'h55AA55AA; bm_adr = 22'h200004;
        bm_cyc = 1'b1; bm_stb = 1'b1;
        tick();
`ifdef WB_TIMEOUT_EN
        ack_at = -1; got_dat = 32'd0;
        for (int i = 1; i <= 20 && ack_at < 0; i++) begin
            tick();
            if (sn_bm_ack) begin ack_at = i; got_dat = sn_bm_dat; end
        end
        chk("to_ack_cycle", 32'(ack_at), 32'd9);
        chk("to_data", got_dat, 32'hDEADDEAD);
        tick();
        chk("to_mask_a", 32'(sn_s1_stb), 32'd0);
        chk("to_no_reack", 32'(sn_bm_ack), 32'd0);
        tick();
        chk("to_mask_b", 32'(sn_s1_stb), 32'd0);
`else
        n_ack = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (sn_bm_ack) n_ack++;
        end
        chk("no_to_acks", 32'(n_ack), 32'd0);
        chk("no_to_stb", 32'(sn_s1_stb), 32'd1);
`endif
        bm_cyc = 1'b0; bm_stb = 1'b0;
        tick(); tick();

        // reset pulsed while bm holds a granted, unanswered s0 access
        lat0 = -1; rd0 = 32'hCAFEF00D; bm_adr = 22'h000010;
        bm_cyc = 1'b1; bm_stb = 1'b1;
        tick(); tick(); tick();
        chk("rmid_stb", 32'(sn_s0_stb), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        chk("rmid_bm_ack", 32'(sn_bm_ack), 32'd0);
        chk("rmid_s0_cyc", 32'(sn_s0_cyc), 32'd0);
        chk("rmid_s0_stb", 32'(sn_s0_stb), 32'd0);
        lat0 = 0;
        tick();
        chk("rmid_new_ack", 32'(sn_bm_ack), 32'd1);
        chk("rmid_new_dat", sn_bm_dat, 32'hCAFEF00D);
        bm_cyc = 1'b0; bm_stb = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
